// File: rtl/vt52_pkg.sv
// rtl/vt52_pkg.sv - ASCII constants and flow-control state encodings shared by the VT52 receive path
package vt52_pkg;

  localparam logic [7:0] ASCII_NUL  = 8'h00;
  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam logic [7:0] ASCII_TAB  = 8'h09;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_XON  = 8'h11;
  localparam logic [7:0] ASCII_XOFF = 8'h13;
  localparam logic [7:0] ASCII_ESC  = 8'h1B;
  localparam logic [7:0] ASCII_DEL  = 8'h7F;

  typedef enum logic [1:0] {
    FLOW_ON        = 2'd0,
    FLOW_SEND_XOFF = 2'd1,
    FLOW_OFF       = 2'd2,
    FLOW_SEND_XON  = 2'd3
  } flow_state_e;

endpackage

// File: rtl/byte_fifo_mem.sv
// rtl/byte_fifo_mem.sv - DEPTH x 8 byte storage, synchronous write, asynchronous read
module byte_fifo_mem #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_byte_fifo.sv
// rtl/rx_byte_fifo.sv - UART rx byte FIFO with NUL/DEL filtering and optional XON/XOFF throttling
// Define RX_FIFO_XONXOFF_EN to build the XON/XOFF flow-control FSM.
module rx_byte_fifo
  import vt52_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_BITS  = 4,
  parameter int XOFF_LEVEL = 12,
  parameter int XON_LEVEL  = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       overflow,
  output logic       xoff_active
);

  localparam logic [ADDR_BITS:0] CNT_FULL = (ADDR_BITS+1)'(DEPTH);

  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic [7:0]           rdata;
  logic                 is_fill, wr_req, full, do_push, do_pop;

  assign is_fill = (in_data == ASCII_NUL) || (in_data == ASCII_DEL);
  assign wr_req  = in_valid && !is_fill;
  assign full    = (count == CNT_FULL);
  assign do_pop  = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = wr_req && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_req && full && !do_pop) overflow <= 1'b1;
    end
  end

  byte_fifo_mem #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (do_push && !clr),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign out_valid = (count != '0);
  // Storage is never reset, so present zero rather than stale contents when empty.
  assign out_data  = out_valid ? rdata : 8'h00;

`ifdef RX_FIFO_XONXOFF_EN
  localparam logic [ADDR_BITS:0] XOFF_CNT = (ADDR_BITS+1)'(XOFF_LEVEL);
  localparam logic [ADDR_BITS:0] XON_CNT  = (ADDR_BITS+1)'(XON_LEVEL);

  flow_state_e state, state_nx;
  logic        tx_valid_nx, xoff_nx;
  logic [7:0]  tx_data_nx;

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= FLOW_ON;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      xoff_active <= 1'b0;
    end else begin
      state       <= state_nx;
      tx_valid    <= tx_valid_nx;
      tx_data     <= tx_data_nx;
      xoff_active <= xoff_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    xoff_nx     = xoff_active;
    tx_valid_nx = 1'b0;
    tx_data_nx  = 8'h00;
    case (state)
      FLOW_ON:        if (count >= XOFF_CNT) state_nx = FLOW_SEND_XOFF;
      FLOW_SEND_XOFF: if (tx_ready) begin
                        state_nx = FLOW_OFF;
                        xoff_nx  = 1'b1;
                      end
      FLOW_OFF:       if (count <= XON_CNT) state_nx = FLOW_SEND_XON;
      FLOW_SEND_XON:  if (tx_ready) begin
                        state_nx = FLOW_ON;
                        xoff_nx  = 1'b0;
                      end
      default:        state_nx = FLOW_ON;
    endcase
    // tx outputs are registered from the upcoming state so they track it with no extra cycle.
    if (state_nx == FLOW_SEND_XOFF) begin
      tx_valid_nx = 1'b1;
      tx_data_nx  = ASCII_XOFF;
    end else if (state_nx == FLOW_SEND_XON) begin
      tx_valid_nx = 1'b1;
      tx_data_nx  = ASCII_XON;
    end
  end
`else
  localparam bit unused_flow_levels = (XON_LEVEL < XOFF_LEVEL);
  logic unused_tx_ready;

  assign unused_tx_ready = tx_ready;
  assign tx_valid        = 1'b0;
  assign tx_data         = 8'h00;
  assign xoff_active     = 1'b0;
`endif

endmodule

// File: tb/tb_rx_byte_fifo.sv
// tb/tb_rx_byte_fifo.sv - directed scoreboard bench for rx_byte_fifo
module tb_rx_byte_fifo;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       overflow;
  logic       xoff_active;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] q[$];
  logic       exp_ovf;

  rx_byte_fifo dut (
    .clk         (clk),
    .clr         (clr),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .overflow    (overflow),
    .xoff_active (xoff_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, compare outputs against the scoreboard, update the model, step.
  task automatic cyc(input logic [7:0] d, input logic v, input logic rdy);
    in_data   = d;
    in_valid  = v;
    out_ready = rdy;
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
`ifndef RX_FIFO_XONXOFF_EN
    chk("tx_valid_off", {31'd0, tx_valid}, 32'd0);
`endif
    if (q.size() != 0) chk("out_data", {24'd0, out_data}, {24'd0, q[0]});
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (v && d != 8'h00 && d != 8'h7F) begin
      if (q.size() < 16) q.push_back(d);
      else exp_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] d, input logic v, input logic rdy);
    clr       = 1'b1;
    in_data   = d;
    in_valid  = v;
    out_ready = rdy;
    tx_ready  = 1'b1;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    tx_ready = 1'b0;
    q.delete();
    exp_ovf = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_xoff", {31'd0, xoff_active}, 32'd0);
  endtask

  initial begin
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tx_ready  = 1'b0;
    exp_ovf   = 1'b0;
    do_reset(8'h00, 1'b0, 1'b0);

    // 1: streaming with fall-through latency
    cyc(8'h41, 1'b1, 1'b1);
    cyc(8'h42, 1'b1, 1'b1);
    cyc(8'h43, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, 1'b1);
    chk("t1_drained", {31'd0, out_valid}, 32'd0);

    // 2: overflow, 0x40 dropped, then drain
    for (int i = 0; i < 17; i++) cyc(8'h30 + 8'(i), 1'b1, 1'b0);
    chk("t2_overflow", {31'd0, overflow}, 32'd1);
    chk("t2_depth", q.size(), 32'd16);
    for (int i = 0; i < 17; i++) cyc(8'h00, 1'b0, 1'b1);
    chk("t2_ovf_sticky", {31'd0, overflow}, 32'd1);

    // 3: fill characters filtered
    do_reset(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b1, 1'b1);
    cyc(8'h7F, 1'b1, 1'b1);
    chk("t3_no_fill", {31'd0, out_valid}, 32'd0);
    cyc(8'h1B, 1'b1, 1'b1);
    chk("t3_esc", {24'd0, out_data}, 32'h1B);
    cyc(8'h00, 1'b0, 1'b1);

    // 4: full FIFO with simultaneous push and pop
    do_reset(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(8'h60 + 8'(i), 1'b1, 1'b0);
    cyc(8'h55, 1'b1, 1'b1);
    chk("t4_no_ovf", {31'd0, overflow}, 32'd0);
    chk("t4_still_full", q.size(), 32'd16);
    for (int i = 0; i < 15; i++) cyc(8'h00, 1'b0, 1'b1);
    chk("t4_last", {24'd0, out_data}, 32'h55);
    cyc(8'h00, 1'b0, 1'b1);
    chk("t4_empty", {31'd0, out_valid}, 32'd0);

`ifdef RX_FIFO_XONXOFF_EN
    // 5: XOFF at 12, held until tx_ready, XON at 4
    do_reset(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(8'h20 + 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4 && !tx_valid; i++) cyc(8'h00, 1'b0, 1'b0);
    chk("t5_xoff_req", {31'd0, tx_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t5_xoff_hold", {31'd0, tx_valid}, 32'd1);
      chk("t5_xoff_data", {24'd0, tx_data}, 32'h13);
      chk("t5_not_off", {31'd0, xoff_active}, 32'd0);
      cyc(8'h00, 1'b0, 1'b0);
    end
    tx_ready = 1'b1;
    cyc(8'h00, 1'b0, 1'b0);
    tx_ready = 1'b0;
    chk("t5_xoff_done", {31'd0, tx_valid}, 32'd0);
    chk("t5_xoff_active", {31'd0, xoff_active}, 32'd1);
    for (int i = 0; i < 8; i++) cyc(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4 && !tx_valid; i++) cyc(8'h00, 1'b0, 1'b0);
    chk("t5_xon_req", {31'd0, tx_valid}, 32'd1);
    chk("t5_xon_data", {24'd0, tx_data}, 32'h11);
    chk("t5_still_off", {31'd0, xoff_active}, 32'd1);
    tx_ready = 1'b1;
    cyc(8'h00, 1'b0, 1'b0);
    tx_ready = 1'b0;
    chk("t5_xon_done", {31'd0, tx_valid}, 32'd0);
    chk("t5_xon_active", {31'd0, xoff_active}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(8'h00, 1'b0, 1'b1);
`endif

    // 6: clr mid-transfer with count 7 (XOFF pending when flow control is built)
    do_reset(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(8'h40 + 8'(i), 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(8'h00, 1'b0, 1'b1);
    chk("t6_count7", q.size(), 32'd7);
`ifdef RX_FIFO_XONXOFF_EN
    chk("t6_tx_pending", {31'd0, tx_valid}, 32'd1);
`endif
    do_reset(8'h41, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, 1'b0);
    chk("t6_flow_on", {31'd0, tx_valid}, 32'd0);
    cyc(8'h5A, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
